led_bar_monitor: RTL and testbench

Checker and decoder for the 8-LED fill-bar bus driven by the team's LED chaser. It samples the bar every clock and classifies the pattern as one of three kinds: empty, a TSP fill (lights enter at bit 7 and grow toward bit 0), or a PST fill (lights enter at bit 0 and grow toward bit 7). It reports fill level, fill direction, completed wraps and a legal-step count, and raises a sticky error on any pattern or transition the chaser can never legally produce. It sits beside the chaser, on the receiving side of its `out` bus, for on-board self-check and for driving a 7-segment level display.

---
 rtl/led_bar_monitor_if.sv | 13 +
 rtl/led_bar_monitor.sv | 55 +++++
 tb/tb_led_bar_monitor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_bar_monitor_if.sv
// led_bar_monitor_if: fill-bar bus from the chaser plus the monitor's decoded status.
interface led_bar_monitor_if;
    logic [7:0] bar;
    logic [3:0] level;
    logic       mode;
    logic       mode_valid;
    logic       wrap;
    logic [7:0] steps;
    logic       err;
    logic       err_pulse;
    modport master (output bar, input level, mode, mode_valid, wrap, steps, err, err_pulse);
    modport slave (input bar, output level, mode, mode_valid, wrap, steps, err, err_pulse);
endinterface

// File: rtl/led_bar_monitor.sv
// led_bar_monitor: classifies the 8-LED fill bar, tracks level/direction/wraps/steps,
// and latches a sticky error on any pattern or transition the chaser cannot produce.
module led_bar_monitor (
    input logic clk,
    input logic reset,
    led_bar_monitor_if.slave bus
);
    typedef enum logic [2:0] {IDLE, TSP, PST, FULL, ERROR} state_t;
    state_t     state;
    logic [7:0] prev;
    logic       hold, adv_tsp, adv_pst, wrap_t, abort_t, legal;
    // prev is always a legal pattern outside ERROR, so the thermometer tests on prev pin down the state
    assign hold    = bus.bar == prev;
    assign adv_tsp = ((~prev & (~prev + 8'd1)) == 8'd0) && prev != 8'hFF && bus.bar == ((prev >> 1) | 8'h80);
    assign adv_pst = ((prev & (prev + 8'd1)) == 8'd0) && prev != 8'hFF && bus.bar == ((prev << 1) | 8'h01);
    assign wrap_t  = prev == 8'hFF && bus.bar == 8'h00;
    assign abort_t = bus.bar == 8'h00 && prev != 8'h00 && prev != 8'hFF;
    assign legal   = hold | adv_tsp | adv_pst | wrap_t | abort_t;
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            prev           <= 8'h00;
            bus.level      <= 4'd0;
            bus.mode       <= 1'b0;
            bus.mode_valid <= 1'b0;
            bus.wrap       <= 1'b0;
            bus.steps      <= 8'd0;
            bus.err        <= 1'b0;
            bus.err_pulse  <= 1'b0;
        end else begin
            prev <= bus.bar;
            if (state == ERROR) begin
                bus.wrap      <= 1'b0;
                bus.err_pulse <= 1'b0;
            end else if (!legal) begin
                state          <= ERROR;
                bus.level      <= 4'd0;
                bus.mode_valid <= 1'b0;
                bus.wrap       <= 1'b0;
                bus.err        <= 1'b1;
                bus.err_pulse  <= 1'b1;
            end else begin
                state          <= bus.bar == 8'h00 ? IDLE :
                                  bus.bar == 8'hFF ? FULL :
                                  adv_tsp ? TSP : adv_pst ? PST : state;
                bus.level      <= 4'($countones(bus.bar));
                bus.mode_valid <= bus.bar != 8'h00;
                bus.mode       <= adv_tsp ? 1'b0 : adv_pst ? 1'b1 : bus.mode;
                bus.wrap       <= wrap_t;
                bus.err_pulse  <= 1'b0;
                bus.steps      <= bus.steps + {7'd0, (adv_tsp | adv_pst) && bus.steps != 8'hFF};
            end
        end
    end
endmodule

// File: tb/tb_led_bar_monitor.sv
// tb_led_bar_monitor: directed scenarios with hand-computed expectations for led_bar_monitor.
module tb_led_bar_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   wraps;
    logic [7:0] tsp_v [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] pst_v [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    led_bar_monitor_if bus ();
    led_bar_monitor dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick(input logic [7:0] v);
        bus.bar = v;
        @(posedge clk);
        #1;
        wraps += int'(bus.wrap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(8'h00);
        reset = 1'b0;
        wraps = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(8'hC1);
        compared++;
        if ({bus.level, bus.mode, bus.mode_valid, bus.wrap, bus.steps, bus.err, bus.err_pulse} !== 17'd0) begin
            mismatched++;
            $display("FAIL reset_outputs got lvl=%0d mode=%b mv=%b wrap=%b steps=%0d err=%b ep=%b want all zero",
                     bus.level, bus.mode, bus.mode_valid, bus.wrap, bus.steps, bus.err, bus.err_pulse);
        end
        reset = 1'b0;
    endtask

    task automatic test_tsp_fill();
        do_reset();
        tick(8'h00);
        compared++;
        if (bus.level !== 4'd0 || bus.mode_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL tsp_start got lvl=%0d mv=%b want 0 0", bus.level, bus.mode_valid);
        end
        for (int i = 0; i < 8; i++) begin
            tick(tsp_v[i]);
            compared++;
            if (bus.level !== 4'(i + 1) || bus.mode !== 1'b0 || bus.mode_valid !== 1'b1 || bus.wrap !== 1'b0) begin
                mismatched++;
                $display("FAIL tsp_step%0d got lvl=%0d mode=%b mv=%b wrap=%b want %0d 0 1 0",
                         i, bus.level, bus.mode, bus.mode_valid, bus.wrap, i + 1);
            end
        end
        tick(8'h00);
        compared++;
        if (bus.wrap !== 1'b1 || bus.level !== 4'd0 || bus.mode_valid !== 1'b0 || bus.steps !== 8'd8 || bus.err !== 1'b0) begin
            mismatched++;
            $display("FAIL tsp_wrap got wrap=%b lvl=%0d mv=%b steps=%0d err=%b want 1 0 0 8 0",
                     bus.wrap, bus.level, bus.mode_valid, bus.steps, bus.err);
        end
        tick(8'h00);
        compared++;
        if (bus.wrap !== 1'b0 || wraps != 1) begin
            mismatched++;
            $display("FAIL tsp_wrap_width got wrap=%b count=%0d want 0 1", bus.wrap, wraps);
        end
    endtask

    task automatic test_pst_hold();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            for (int h = 0; h < 3; h++) begin
                tick(pst_v[i]);
                compared++;
                if (bus.level !== 4'(i + 1) || bus.mode !== 1'b1 || bus.mode_valid !== 1'b1 || bus.err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL pst_hold%0d_%0d got lvl=%0d mode=%b mv=%b err=%b want %0d 1 1 0",
                             i, h, bus.level, bus.mode, bus.mode_valid, bus.err, i + 1);
                end
            end
        end
        tick(8'h00);
        compared++;
        if (bus.steps !== 8'd8 || wraps != 1 || bus.err !== 1'b0 || bus.mode !== 1'b1) begin
            mismatched++;
            $display("FAIL pst_wrap got steps=%0d wraps=%0d err=%b mode=%b want 8 1 0 1", bus.steps, wraps, bus.err, bus.mode);
        end
    endtask

    task automatic test_dir_change();
        do_reset();
        tick(8'h80);
        tick(8'hC0);
        tick(8'hE0);
        tick(8'hC1);
        compared++;
        if (bus.err_pulse !== 1'b1 || bus.err !== 1'b1 || bus.level !== 4'd0 || bus.mode_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL dir_err got ep=%b err=%b lvl=%0d mv=%b want 1 1 0 0", bus.err_pulse, bus.err, bus.level, bus.mode_valid);
        end
        tick(8'h00);
        compared++;
        if (bus.err_pulse !== 1'b0 || bus.err !== 1'b1 || bus.level !== 4'd0 || bus.steps !== 8'd3) begin
            mismatched++;
            $display("FAIL dir_sticky got ep=%b err=%b lvl=%0d steps=%0d want 0 1 0 3", bus.err_pulse, bus.err, bus.level, bus.steps);
        end
        tick(8'h80);
        compared++;
        if (bus.err !== 1'b1 || bus.level !== 4'd0 || bus.steps !== 8'd3 || bus.mode_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL err_absorb got err=%b lvl=%0d steps=%0d mv=%b want 1 0 3 0", bus.err, bus.level, bus.steps, bus.mode_valid);
        end
        do_reset();
        compared++;
        if (bus.err !== 1'b0) begin
            mismatched++;
            $display("FAIL err_cleared got err=%b want 0", bus.err);
        end
    endtask

    task automatic test_skip_and_cross();
        do_reset();
        tick(8'h80);
        tick(8'hE0);
        compared++;
        if (bus.err_pulse !== 1'b1 || bus.steps !== 8'd1) begin
            mismatched++;
            $display("FAIL skip_step got ep=%b steps=%0d want 1 1", bus.err_pulse, bus.steps);
        end
        do_reset();
        tick(8'h80);
        tick(8'hC0);
        tick(8'hE0);
        tick(8'h01);
        compared++;
        if (bus.err_pulse !== 1'b1 || bus.err !== 1'b1) begin
            mismatched++;
            $display("FAIL cross_dir got ep=%b err=%b want 1 1", bus.err_pulse, bus.err);
        end
        do_reset();
        for (int i = 0; i < 8; i++) tick(tsp_v[i]);
        tick(8'h7F);
        tick(8'h00);
        compared++;
        if (wraps != 0 || bus.err !== 1'b1 || bus.err_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap_in_err got wraps=%0d err=%b ep=%b want 0 1 0", wraps, bus.err, bus.err_pulse);
        end
    endtask

    task automatic test_abort();
        do_reset();
        tick(8'h80);
        tick(8'hC0);
        tick(8'hE0);
        tick(8'h00);
        compared++;
        if (bus.wrap !== 1'b0 || bus.err !== 1'b0 || bus.mode_valid !== 1'b0 || bus.level !== 4'd0 || bus.steps !== 8'd3) begin
            mismatched++;
            $display("FAIL abort got wrap=%b err=%b mv=%b lvl=%0d steps=%0d want 0 0 0 0 3",
                     bus.wrap, bus.err, bus.mode_valid, bus.level, bus.steps);
        end
        tick(8'h01);
        compared++;
        if (bus.mode !== 1'b1 || bus.mode_valid !== 1'b1 || bus.level !== 4'd1 || bus.err !== 1'b0 || bus.steps !== 8'd4) begin
            mismatched++;
            $display("FAIL abort_then_pst got mode=%b mv=%b lvl=%0d err=%b steps=%0d want 1 1 1 0 4",
                     bus.mode, bus.mode_valid, bus.level, bus.err, bus.steps);
        end
    endtask

    task automatic test_bad_first();
        do_reset();
        tick(8'hFF);
        compared++;
        if (bus.err_pulse !== 1'b1 || bus.err !== 1'b1 || bus.steps !== 8'd0 || bus.level !== 4'd0) begin
            mismatched++;
            $display("FAIL first_ff got ep=%b err=%b steps=%0d lvl=%0d want 1 1 0 0", bus.err_pulse, bus.err, bus.steps, bus.level);
        end
        tick(8'hFF);
        compared++;
        if (bus.err_pulse !== 1'b0 || bus.err !== 1'b1) begin
            mismatched++;
            $display("FAIL first_ff_pulse got ep=%b err=%b want 0 1", bus.err_pulse, bus.err);
        end
        do_reset();
        tick(8'h03);
        compared++;
        if (bus.err_pulse !== 1'b1 || bus.steps !== 8'd0) begin
            mismatched++;
            $display("FAIL first_03 got ep=%b steps=%0d want 1 0", bus.err_pulse, bus.steps);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < 32; c++) begin
            for (int i = 0; i < 8; i++) tick(tsp_v[i]);
            tick(8'h00);
            if (c == 30) begin
                compared++;
                if (bus.steps !== 8'd248) begin
                    mismatched++;
                    $display("FAIL steps_31 got %0d want 248", bus.steps);
                end
            end
        end
        compared++;
        if (bus.steps !== 8'd255 || wraps != 32 || bus.err !== 1'b0) begin
            mismatched++;
            $display("FAIL saturate got steps=%0d wraps=%0d err=%b want 255 32 0", bus.steps, wraps, bus.err);
        end
        tick(8'h80);
        tick(8'hC0);
        compared++;
        if (bus.steps !== 8'd255 || bus.level !== 4'd2) begin
            mismatched++;
            $display("FAIL saturate_hold got steps=%0d lvl=%0d want 255 2", bus.steps, bus.level);
        end
        reset = 1'b1;
        tick(8'hE0);
        compared++;
        if ({bus.level, bus.mode, bus.mode_valid, bus.wrap, bus.steps, bus.err, bus.err_pulse} !== 17'd0) begin
            mismatched++;
            $display("FAIL midfill_reset got lvl=%0d mode=%b mv=%b wrap=%b steps=%0d err=%b ep=%b want all zero",
                     bus.level, bus.mode, bus.mode_valid, bus.wrap, bus.steps, bus.err, bus.err_pulse);
        end
        reset = 1'b0;
        tick(8'h80);
        compared++;
        if (bus.err !== 1'b0 || bus.steps !== 8'd1 || bus.level !== 4'd1) begin
            mismatched++;
            $display("FAIL post_reset got err=%b steps=%0d lvl=%0d want 0 1 1", bus.err, bus.steps, bus.level);
        end
    endtask

    initial begin
        bus.bar = 8'h00;
        wraps = 0;
        test_reset();
        test_tsp_fill();
        test_pst_hold();
        test_dir_change();
        test_skip_and_cross();
        test_abort();
        test_bad_first();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
